// File: rtl/div_ctrl_if.sv
// Request/response bundle between the E stage and the iterative divider.
// The E stage drives the request side (master); div_ctrl answers (slave).
interface div_ctrl_if #(parameter int WIDTH = 32);
  logic               start;
  logic               signed_div;
  logic [WIDTH-1:0]   opdata1;
  logic [WIDTH-1:0]   opdata2;
  logic               flush;
  logic               ack;
  logic               div_stall;
  logic               ready;
  logic [2*WIDTH-1:0] result;

  modport master (
    output start, signed_div, opdata1, opdata2, flush, ack,
    input  div_stall, ready, result
  );

  modport slave (
    input  start, signed_div, opdata1, opdata2, flush, ack,
    output div_stall, ready, result
  );
endinterface

// File: rtl/div_ctrl.sv
// Execute-stage iterative divider controller: one restoring radix-2 step per
// cycle on operand magnitudes, with sign fix-up on the last step. The result
// is held as {remainder, quotient} until the pipeline acknowledges it.
// Optional feature macro: DIV_EARLY_OUT_EN. When it is defined, a dividend
// whose magnitude is below the divisor's completes in one cycle.
module div_ctrl #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  div_ctrl_if.slave bus
);
  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, DIVZERO, BUSY, DONE} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  // {partial remainder, dividend/quotient}; quotient bits shift in at the LSB
  logic [2*WIDTH-1:0]   rem_dvd;
  logic [WIDTH-1:0]     dvsr;
  logic                 neg1, neg2;
  logic [2*WIDTH-1:0]   result_q;

  // Operand signs only matter for DIV; the most negative value negates to
  // itself and is then read as an unsigned magnitude.
  logic                 op1_neg, op2_neg;
  logic [WIDTH-1:0]     abs1, abs2;
  assign op1_neg = bus.signed_div & bus.opdata1[WIDTH-1];
  assign op2_neg = bus.signed_div & bus.opdata2[WIDTH-1];
  assign abs1    = op1_neg ? -bus.opdata1 : bus.opdata1;
  assign abs2    = op2_neg ? -bus.opdata2 : bus.opdata2;

  // One restoring step: shift left, trial-subtract from the upper WIDTH+1
  // bits, keep the difference only when it did not go negative.
  logic [2*WIDTH:0]     shifted;
  logic [WIDTH:0]       diff;
  logic [2*WIDTH-1:0]   step;
  logic [WIDTH-1:0]     quo, rmd, fix_q, fix_r;
  assign shifted = {rem_dvd, 1'b0};
  assign diff    = shifted[2*WIDTH:WIDTH] - {1'b0, dvsr};
  assign step    = diff[WIDTH] ? shifted[2*WIDTH-1:0]
                               : {diff[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1};
  assign quo     = step[WIDTH-1:0];
  assign rmd     = step[2*WIDTH-1:WIDTH];
  assign fix_q   = (neg1 ^ neg2) ? -quo : quo;
  assign fix_r   = neg1 ? -rmd : rmd;

  // Stall is combinational so the hazard unit sees it in the start cycle.
  assign bus.div_stall = (state == IDLE & bus.start & ~bus.flush) |
                         (state == DIVZERO) | (state == BUSY);
  assign bus.ready     = (state == DONE);
  assign bus.result    = result_q;

  // Sequencing FSM and datapath registers; flush wins over everything and
  // never touches the held result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rem_dvd  <= '0;
      dvsr     <= '0;
      neg1     <= 1'b0;
      neg2     <= 1'b0;
      result_q <= '0;
    end else if (bus.flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          if (bus.opdata2 == '0) begin
            state   <= DIVZERO;
            rem_dvd <= {{WIDTH{1'b0}}, bus.opdata1};
          end
`ifdef DIV_EARLY_OUT_EN
          else if (abs1 < abs2) begin
            state    <= DONE;
            result_q <= {bus.opdata1, {WIDTH{1'b0}}};
          end
`endif
          else begin
            state   <= BUSY;
            rem_dvd <= {{WIDTH{1'b0}}, abs1};
            dvsr    <= abs2;
            neg1    <= op1_neg;
            neg2    <= op2_neg;
            cnt     <= '0;
          end
        end
        DIVZERO: begin
          state    <= DONE;
          result_q <= {rem_dvd[WIDTH-1:0], {WIDTH{1'b1}}};
        end
        BUSY: begin
          rem_dvd <= step;
          cnt     <= cnt + CW'(1);
          if (cnt == LAST) begin
            state    <= DONE;
            result_q <= {fix_r, fix_q};
          end
        end
        DONE: if (bus.ack) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed cases, hold/back-to-back,
// flush, async reset and randomized operations against an arithmetic model.
module tb_div_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_ctrl_if #(.WIDTH(32)) bus ();
  div_ctrl #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

`ifdef DIV_EARLY_OUT_EN
  localparam int SHORT = 1;
`else
  localparam int SHORT = 33;
`endif

  // Reference result from plain integer arithmetic (C-style truncation).
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit sg);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  // Expected cycles from the start cycle to the first ready cycle.
  function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b, input bit sg);
    logic [31:0] ma, mb;
    if (b == 32'd0) return 2;
    ma = (sg && a[31]) ? 32'd0 - a : a;
    mb = (sg && b[31]) ? 32'd0 - b : b;
    if (ma < mb) return SHORT;
    return 33;
  endfunction

  // Drive a request at a negedge and wait (bounded) for ready.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input bit sg,
                        output int lat, output logic [63:0] res, output bit stall_ok);
    bus.start = 1'b1; bus.signed_div = sg; bus.opdata1 = a; bus.opdata2 = b;
    bus.flush = 1'b0; bus.ack = 1'b0;
    #1;
    stall_ok = bus.div_stall;
    lat = 0;
    while (!bus.ready && lat < 40) begin
      @(negedge clk);
      lat++;
      if (!bus.ready && !bus.div_stall) stall_ok = 1'b0;
      if (bus.ready && bus.div_stall) stall_ok = 1'b0;
    end
    res = bus.result;
  endtask

  task automatic finish_op(input bit use_flush);
    bus.ack = use_flush ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.flush = use_flush;
    bus.start = 1'b0;
    @(negedge clk);
    bus.ack = 1'b0; bus.flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.start = 0; bus.signed_div = 0; bus.opdata1 = 0; bus.opdata2 = 0;
    bus.flush = 0; bus.ack = 0;
    #2;
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", bus.ready); end
    checks++; if (bus.div_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", bus.div_stall); end
    checks++; if (bus.result !== 64'd0) begin errors++; $display("FAIL reset_result got %h exp 0", bus.result); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [31:0] da [8] = '{32'd100, 32'hFFFF_FFF9, 32'h8000_0000, 32'd5, 32'd3, 32'hFFFF_FFF9, 32'hFFFF_FFFD, 32'h8000_0000};
    logic [31:0] db [8] = '{32'd7, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'd10, 32'd0, 32'd10, 32'h8000_0000};
    bit          ds [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [63:0] dr [8] = '{{32'd2, 32'd14}, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, {32'd0, 32'h8000_0000},
                            {32'd5, 32'hFFFF_FFFF}, {32'd3, 32'd0}, {32'hFFFF_FFF9, 32'hFFFF_FFFF},
                            {32'hFFFF_FFFD, 32'd0}, {32'd0, 32'd1}};
    int          dl [8] = '{33, 33, 33, 2, SHORT, 2, SHORT, 33};
    int lat; logic [63:0] res; bit sok;
    for (int i = 0; i < 8; i++) begin
      do_div(da[i], db[i], ds[i], lat, res, sok);
      checks++; if (lat !== dl[i]) begin errors++; $display("FAIL dir%0d_latency got %0d exp %0d", i, lat, dl[i]); end
      checks++; if (res !== dr[i]) begin errors++; $display("FAIL dir%0d_result got %h exp %h", i, res, dr[i]); end
      checks++; if (sok !== 1'b1) begin errors++; $display("FAIL dir%0d_stall got bad exp good", i); end
      finish_op(1'b0);
      checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL dir%0d_ack got ready %b exp 0", i, bus.ready); end
    end
  endtask

  task automatic test_hold_back_to_back();
    int lat; logic [63:0] res; bit sok;
    do_div(32'd1000, 32'd3, 1'b0, lat, res, sok);
    checks++; if (res !== {32'd1, 32'd333}) begin errors++; $display("FAIL hold_result got %h exp %h", res, {32'd1, 32'd333}); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (bus.ready !== 1'b1 || bus.div_stall !== 1'b0 || bus.result !== res) begin
        errors++; $display("FAIL hold_cycle%0d got r=%b s=%b %h exp r=1 s=0 %h", i, bus.ready, bus.div_stall, bus.result, res);
      end
    end
    bus.opdata1 = 32'd77; bus.opdata2 = 32'd5; bus.ack = 1'b1;
    @(negedge clk);
    bus.ack = 1'b0;
    checks++; if (bus.ready !== 1'b0 || bus.div_stall !== 1'b1) begin
      errors++; $display("FAIL b2b_bubble got r=%b s=%b exp r=0 s=1", bus.ready, bus.div_stall);
    end
    do_div(32'd77, 32'd5, 1'b0, lat, res, sok);
    checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_latency got %0d exp 33", lat); end
    checks++; if (res !== {32'd2, 32'd15}) begin errors++; $display("FAIL b2b_result got %h exp %h", res, {32'd2, 32'd15}); end
    finish_op(1'b0);
  endtask

  task automatic test_flush();
    logic [63:0] prev; int lat; logic [63:0] res; bit sok; bit seen;
    prev = bus.result;
    bus.start = 1'b1; bus.signed_div = 1'b0; bus.opdata1 = 32'd1000; bus.opdata2 = 32'd7;
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    checks++; if (bus.div_stall !== 1'b0 || bus.ready !== 1'b0) begin
      errors++; $display("FAIL flush_busy got s=%b r=%b exp s=0 r=0", bus.div_stall, bus.ready);
    end
    seen = 1'b0;
    repeat (3) begin @(negedge clk); if (bus.ready || bus.div_stall) seen = 1'b1; end
    bus.flush = 1'b0; bus.start = 1'b0;
    repeat (40) begin @(negedge clk); if (bus.ready) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_ready got activity exp none"); end
    checks++; if (bus.result !== prev) begin errors++; $display("FAIL flush_result got %h exp %h", bus.result, prev); end
    do_div(32'd50, 32'd6, 1'b0, lat, res, sok);
    prev = res;
    bus.flush = 1'b1; bus.start = 1'b0;
    @(negedge clk);
    bus.flush = 1'b0;
    checks++; if (bus.ready !== 1'b0 || bus.result !== prev) begin
      errors++; $display("FAIL flush_done got r=%b %h exp r=0 %h", bus.ready, bus.result, prev);
    end
  endtask

  task automatic test_async_reset();
    int lat; logic [63:0] res; bit sok;
    bus.start = 1'b1; bus.signed_div = 1'b0; bus.opdata1 = 32'd999; bus.opdata2 = 32'd4;
    repeat (5) @(negedge clk);
    bus.start = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++; if (bus.ready !== 1'b0 || bus.div_stall !== 1'b0 || bus.result !== 64'd0) begin
      errors++; $display("FAIL async_rst got r=%b s=%b %h exp all 0", bus.ready, bus.div_stall, bus.result);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    do_div(32'd999, 32'd4, 1'b0, lat, res, sok);
    checks++; if (lat !== 33 || res !== {32'd3, 32'd249}) begin
      errors++; $display("FAIL async_recover got lat=%0d %h exp lat=33 %h", lat, res, {32'd3, 32'd249});
    end
    finish_op(1'b0);
  endtask

  task automatic test_random();
    logic [31:0] a, b; bit sg; int lat; logic [63:0] res, exp; bit sok;
    for (int i = 0; i < 40; i++) begin
      a = $urandom; sg = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = 32'd0 - $urandom_range(1, 15);
        3: begin b = $urandom; a = $urandom_range(0, 40); end
        default: b = $urandom;
      endcase
      exp = ref_div(a, b, sg);
      do_div(a, b, sg, lat, res, sok);
      checks++; if (res !== exp || lat !== ref_lat(a, b, sg) || sok !== 1'b1) begin
        errors++; $display("FAIL rand%0d a=%h b=%h s=%b got %h lat %0d exp %h lat %0d", i, a, b, sg, res, lat, exp, ref_lat(a, b, sg));
      end
      finish_op($urandom_range(0, 3) == 0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_hold_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/div_ctrl.md
# div_ctrl

Sequencing controller for the execute-stage iterative divider. It accepts a DIV/DIVU request from the E stage and runs a 32-step radix-2 restoring division. Until the result is ready it raises a stall toward the hazard unit. It then holds a 64-bit {remainder, quotient} result for the HI/LO write path until the pipeline acknowledges it. A flush aborts any division in flight.

## Interface
Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  E stage holds a DIV/DIVU; level, not pulse.
- signed_div  in  1  1 = DIV (signed), 0 = DIVU; sampled with start in IDLE.
- opdata1  in  WIDTH  dividend; sampled in IDLE when start=1.
- opdata2  in  WIDTH  divisor; sampled in IDLE when start=1.
- flush  in  1  E-stage flush; aborts and discards the operation.
- ack  in  1  E stage advances this cycle; consumes a DONE result.
- div_stall  out  1  stall request to the hazard unit.
- ready  out  1  result valid (state DONE).
- result  out  2*WIDTH  [63:32] = remainder (HI), [31:0] = quotient (LO).

## Operation
- States: IDLE, DIVZERO, BUSY, DONE.
- IDLE:
  - start & ~flush & opdata2==0 → DIVZERO.
  - start & ~flush → BUSY. Latch |opdata1|, |opdata2|, the sign of each operand and signed_div. Clear the step counter.
- DIVZERO → DONE. Result is quotient = all ones and remainder = opdata1 unmodified, for both signed and unsigned.
- BUSY, per cycle: shift the 65-bit partial-remainder:dividend register left by 1. Trial-subtract the divisor from the upper 33 bits. If the difference is non-negative, keep it and set quotient LSB = 1; otherwise set quotient LSB = 0. Increment the counter.
- When the counter reaches 31 (the 32nd step), go to DONE and apply sign fix-up:
  - Negate the quotient if signed_div and the operand signs differ.
  - Negate the remainder if signed_div and the dividend was negative.
- DONE: result is held stable. Go to IDLE on ack or flush; otherwise stay.
- flush in any state → IDLE on the next edge. The result register is not updated.
- Width rules:
  - Absolute values are taken in WIDTH bits. The most negative number maps to itself and is treated as unsigned 2^31.
  - Overflow case 0x80000000 / 0xFFFFFFFF (signed): quotient = 0x80000000, remainder = 0.

## Timing
- Reset:
  - state = IDLE; counter = 0; result = 0.
  - ready = 0; div_stall = 0.
- div_stall is combinational: (start & ~flush & state==IDLE) | state==DIVZERO | state==BUSY.
- div_stall is 0 in DONE so the E stage can advance.
- Latency, with start sampled at edge T:
  - Normal division: BUSY for cycles T+1..T+32; ready=1 from T+33.
  - Divide by zero: DIVZERO at T+1; ready=1 at T+2.
- ack while not in DONE is ignored.
- ack and flush in the same DONE cycle both give IDLE.
- start in DONE does not begin a new operation. A back-to-back divide starts from IDLE on the cycle after ack, so there is one bubble.
- flush has priority over start in IDLE: no transition, and div_stall = 0.
- Asynchronous reset mid-BUSY: immediate IDLE, outputs return to reset values, and the partial result is lost.

## Configuration
- DIV_EARLY_OUT_EN:
  - Defined: in IDLE, an unsigned magnitude compare |opdata1| < |opdata2| (divisor ≠ 0) sends the operation to DONE on the next edge. Quotient = 0 and remainder = opdata1 (sign preserved), so latency is 1 cycle and BUSY is skipped.
  - Undefined: every nonzero-divisor operation takes the full 32-step path, and results are identical.

## Test plan
- Unsigned 100 / 7, start at T → div_stall=1 for T..T+32, then ready=1 at T+33 with result = {32'd2, 32'd14}.
- Signed -7 / 2 (0xFFFFFFF9, 0x2) → result = {0xFFFFFFFF, 0xFFFFFFFD} at T+33. Signed 0x80000000 / 0xFFFFFFFF → {0x0, 0x80000000}.
- 5 / 0 → DIVZERO at T+1, ready at T+2, result = {0x00000005, 0xFFFFFFFF}.
- 3 / 10 with DIV_EARLY_OUT_EN → ready at T+1 with {3, 0}. Without the macro → ready at T+33 with the same value.
- flush at T+10 during BUSY → IDLE at T+11, div_stall=0, ready never asserts, result unchanged. Async rst low at T+5 → immediate IDLE with all outputs 0.
- DONE held with ack=0 for 4 cycles → ready=1 and result stable, div_stall=0. ack=1 → IDLE next cycle. start held high throughout → the next operation begins from IDLE one cycle after ack.
